uart_rx_frame_ctrl: RTL and testbench

Receive-side frame front end of the UART RX. It detects the start bit on the serial line and oversamples each bit with a 3-sample majority vote. It deserializes data LSB-first and sequences start, data, parity and stop. It feeds Parity_Check directly (P_DATA_Par, Sampled_Bit_par_chk, PAR_CHK_EN), takes back PAR_ERR, and issues DATA_VALID plus frame error flags to the RX top level.

---
 rtl/uart_rx_frame_ctrl.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame front end: start detect, 3-sample majority vote,
// LSB-first deserializer and start/data/parity/stop sequencing.
module uart_rx_frame_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_ERR,
    output logic [DATA_WIDTH-1:0]     P_DATA_Par,
    output logic                      Sampled_Bit_par_chk,
    output logic                      PAR_CHK_EN,
    output logic                      STRT_GLITCH,
    output logic                      STP_ERR,
    output logic                      DATA_VALID
);

    localparam int PW = PRESCALE_WIDTH;
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [PW-1:0] ONE = PW'(1);
    localparam logic [PW-1:0] TWO = PW'(2);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e                  state_q, state_d;
    logic [PW-1:0]           cnt_q, cnt_d;
    logic [PW-1:0]           pre_q, pre_d;
    logic                    paren_q, paren_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [2:0]              smp_q, smp_d;
    logic                    bitv_q, bitv_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    chk_q, chk_d;
    logic                    glitch_q, glitch_d;
    logic                    stperr_q, stperr_d;
    logic                    valid_q, valid_d;

    logic [PW-1:0] half;
    logic          last;
    logic          vote;
    logic          maj;
    logic          cur_bit;

    assign half = pre_q >> 1;
    assign last = (cnt_q == pre_q - ONE);
    assign vote = (cnt_q == half + TWO);
    assign maj  = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2])
                | (smp_q[1] & smp_q[2]);
    // At the smallest prescale the vote lands on the bit-end cycle itself
    assign cur_bit = vote ? maj : bitv_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pre_d    = pre_q;
        paren_d  = paren_q;
        bit_d    = bit_q;
        smp_d    = smp_q;
        bitv_d   = bitv_q;
        data_d   = data_q;
        stperr_d = stperr_q;
        chk_d    = 1'b0;
        glitch_d = 1'b0;
        valid_d  = 1'b0;

        if (state_q != IDLE) begin
            cnt_d = last ? '0 : cnt_q + ONE;
            if (cnt_q == half - ONE) smp_d[0] = RX_IN;
            if (cnt_q == half)       smp_d[1] = RX_IN;
            if (cnt_q == half + ONE) smp_d[2] = RX_IN;
            if (vote)                bitv_d   = maj;
        end

        unique case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    state_d  = START;
                    cnt_d    = '0;
                    pre_d    = Prescale;
                    paren_d  = PAR_EN;
                    stperr_d = 1'b0;
                end
            end
            START: begin
                if (last) begin
                    if (cur_bit) begin
                        glitch_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end
            end
            DATA: begin
                if (last) begin
                    data_d = {cur_bit, data_q[DATA_WIDTH-1:1]};
                    bit_d  = bit_q + BW'(1);
                    if (bit_q == LAST_BIT)
                        state_d = paren_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (last) begin
                    chk_d   = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (last) begin
                    stperr_d = ~cur_bit;
                    valid_d  = cur_bit & (~paren_q | ~PAR_ERR);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pre_q    <= '0;
            paren_q  <= 1'b0;
            bit_q    <= '0;
            smp_q    <= '0;
            bitv_q   <= 1'b0;
            data_q   <= '0;
            chk_q    <= 1'b0;
            glitch_q <= 1'b0;
            stperr_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pre_q    <= pre_d;
            paren_q  <= paren_d;
            bit_q    <= bit_d;
            smp_q    <= smp_d;
            bitv_q   <= bitv_d;
            data_q   <= data_d;
            chk_q    <= chk_d;
            glitch_q <= glitch_d;
            stperr_q <= stperr_d;
            valid_q  <= valid_d;
        end
    end

    assign P_DATA_Par          = data_q;
    assign Sampled_Bit_par_chk = bitv_q;
    assign PAR_CHK_EN          = chk_q;
    assign STRT_GLITCH         = glitch_q;
    assign STP_ERR             = stperr_q;
    assign DATA_VALID          = valid_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl; expected pulses are queued
// when a frame is driven and matched when the DUT pulses.
module tb_uart_rx_frame_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_ERR = 1'b0;
    logic [7:0] P_DATA_Par;
    logic       Sampled_Bit_par_chk;
    logic       PAR_CHK_EN;
    logic       STRT_GLITCH;
    logic       STP_ERR;
    logic       DATA_VALID;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // kind: 0 = start glitch, 1 = parity strobe, 2 = data valid
    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] data;
        logic       pbit;
    } ev_t;

    ev_t sb[$];

    uart_rx_frame_ctrl #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .RX_IN               (RX_IN),
        .Prescale            (Prescale),
        .PAR_EN              (PAR_EN),
        .PAR_ERR             (PAR_ERR),
        .P_DATA_Par          (P_DATA_Par),
        .Sampled_Bit_par_chk (Sampled_Bit_par_chk),
        .PAR_CHK_EN          (PAR_CHK_EN),
        .STRT_GLITCH         (STRT_GLITCH),
        .STP_ERR             (STP_ERR),
        .DATA_VALID          (DATA_VALID)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int kind, input int c, input logic [7:0] d,
                        input logic pb);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.data = d;
        e.pbit = pb;
        sb.push_back(e);
    endtask

    // Called at a negedge; start bit is seen at the next rising edge (t0).
    task automatic send(input int p, input bit pe, input logic [7:0] d,
                        input bit badpar, input bit stp, input bit perr,
                        input int noise_bit, input bit rel_rst);
        logic [11:0] bits;
        logic        par;
        int          n;
        int          t0;
        par       = (^d) ^ badpar;
        n         = 10 + int'(pe);
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = d;
        if (pe) bits[9] = par;
        bits[n-1] = stp;
        Prescale  = 6'(p);
        PAR_EN    = pe;
        PAR_ERR   = perr;
        t0        = cyc + 1;
        if (pe) push(1, t0 + (n - 1) * p, d, par);
        if (stp && !(pe && perr)) push(2, t0 + n * p, d, 1'b0);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < p; j++) begin
                RX_IN = bits[i] ^ ((i == noise_bit) && (j == p / 2 + 1));
                if (rel_rst && i == 0 && j == 0) RST = 1'b1;
                if (i == 0 && j == 1) begin
                    Prescale = (p == 8) ? 6'd16 : 6'd8;
                    PAR_EN   = ~pe;
                end
                @(negedge CLK);
            end
        end
        RX_IN = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        int t0;
        fork
            forever begin
                @(negedge CLK);
                if (RST) begin
                    int  npul;
                    int  kind;
                    ev_t e;
                    npul = int'(PAR_CHK_EN) + int'(STRT_GLITCH)
                         + int'(DATA_VALID);
                    if (npul > 1) chk("pulse_excl", npul, 1);
                    if (npul != 0) begin
                        kind = DATA_VALID ? 2 : (PAR_CHK_EN ? 1 : 0);
                        if (sb.size() == 0) begin
                            chk("spurious_pulse", kind, 32'hFFFF_FFFF);
                        end else begin
                            e = sb.pop_front();
                            chk("pulse_kind", kind, e.kind);
                            chk("pulse_cycle", cyc, e.cyc);
                            if (kind != 0)
                                chk("pulse_data", P_DATA_Par, e.data);
                            if (kind == 1)
                                chk("par_bit", Sampled_Bit_par_chk, e.pbit);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge CLK);
        chk("rst_data", P_DATA_Par, 0);
        chk("rst_sbit", Sampled_Bit_par_chk, 0);
        chk("rst_chk", PAR_CHK_EN, 0);
        chk("rst_glitch", STRT_GLITCH, 0);
        chk("rst_stperr", STP_ERR, 0);
        chk("rst_valid", DATA_VALID, 0);
        RST = 1'b1;
        repeat (3) @(negedge CLK);

        send(8, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, -1, 1'b0);
        chk("a5_stperr", STP_ERR, 0);
        repeat (2) @(negedge CLK);

        send(16, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, -1, 1'b0);
        repeat (2) @(negedge CLK);

        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        t0       = cyc + 1;
        push(0, t0 + 8, 8'h00, 1'b0);
        RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (12) @(negedge CLK);
        chk("glitch_noshift", P_DATA_Par, 8'h3C);

        send(8, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        chk("stp_err_set", STP_ERR, 1);
        repeat (5) @(negedge CLK);
        chk("stp_err_held", STP_ERR, 1);

        send(32, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 3, 1'b0);
        chk("stp_err_clr", STP_ERR, 0);
        repeat (2) @(negedge CLK);

        send(8, 1'b1, 8'h0F, 1'b1, 1'b1, 1'b1, -1, 1'b0);
        send(8, 1'b1, 8'hF0, 1'b0, 1'b1, 1'b0, -1, 1'b0);

        Prescale = 6'd8;
        PAR_EN   = 1'b1;
        PAR_ERR  = 1'b0;
        RX_IN    = 1'b0;
        repeat (8) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (12) @(negedge CLK);
        chk("mid_data", P_DATA_Par, 8'hF8);
        #2 RST = 1'b0;
        #1;
        chk("arst_data", P_DATA_Par, 0);
        chk("arst_sbit", Sampled_Bit_par_chk, 0);
        chk("arst_chk", PAR_CHK_EN, 0);
        chk("arst_glitch", STRT_GLITCH, 0);
        chk("arst_stperr", STP_ERR, 0);
        chk("arst_valid", DATA_VALID, 0);
        repeat (3) @(negedge CLK);

        send(6, 1'b1, 8'h81, 1'b0, 1'b1, 1'b0, -1, 1'b1);
        repeat (5) @(negedge CLK);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
